gf32_mul_arbiter: RTL and testbench

- Shares one 32-bit GF multiplier (gf_mul_32 / gf251_mul_32, start/done interface) between two requesters.
  - Port 0: compute_plain_broadcast.
  - Port 1: evaluate.
- Replaces the ad-hoc start-priority operand mux in the signing top level.
- Buffers one request per port, grants round-robin, keeps one operation in flight, routes each result back to its owner, and flags protocol violations and a stalled unit.

---
 rtl/gf32_mul_arbiter.sv | 174 +++++++++++++++++
 tb/tb_gf32_mul_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf32_mul_arbiter.sv
// Two-port arbiter in front of one start/done GF multiplier: one buffered request per port,
// round-robin grant, single operation in flight, stall timeout and sticky protocol-error flags.
module gf32_mul_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start_0,
    input  logic [WIDTH-1:0] i_x_0,
    input  logic [WIDTH-1:0] i_y_0,
    output logic [WIDTH-1:0] o_res_0,
    output logic             o_done_0,
    input  logic             i_start_1,
    input  logic [WIDTH-1:0] i_x_1,
    input  logic [WIDTH-1:0] i_y_1,
    output logic [WIDTH-1:0] o_res_1,
    output logic             o_done_1,
    output logic             o_start_mul,
    output logic [WIDTH-1:0] o_x_mul,
    output logic [WIDTH-1:0] o_y_mul,
    input  logic [WIDTH-1:0] i_o_mul,
    input  logic             i_done_mul,
    output logic             o_busy,
    output logic             o_err_proto,
    output logic             o_err_timeout
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    state_t           state_next;
    logic             pend_0;
    logic             pend_1;
    logic [WIDTH-1:0] x_buf_0;
    logic [WIDTH-1:0] y_buf_0;
    logic [WIDTH-1:0] x_buf_1;
    logic [WIDTH-1:0] y_buf_1;
    logic             rr;
    logic             owner;
    logic [CW-1:0]    count;
    logic             in_flight;
    logic             busy_0;
    logic             busy_1;
    logic             take_0;
    logic             take_1;
    logic             grant;
    logic             issue_sel;
    logic             timed_out;

    // A port stays busy through ISSUE/WAIT of its own op; in RESP a new start is already legal.
    assign in_flight = (state == ISSUE) || (state == WAIT);
    assign busy_0    = pend_0 | (in_flight & ~owner);
    assign busy_1    = pend_1 | (in_flight & owner);
    assign take_0    = i_start_0 & ~busy_0;
    assign take_1    = i_start_1 & ~busy_1;
    assign grant     = (pend_0 & pend_1) ? rr : pend_1;
    assign issue_sel = (state == IDLE) && (pend_0 || pend_1);
    assign timed_out = (count == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pend_0 || pend_1) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (i_done_mul || timed_out) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_start_mul = 1'b0;
        o_done_0    = 1'b0;
        o_done_1    = 1'b0;
        o_busy      = pend_0 | pend_1 | (state != IDLE);
        case (state)
            ISSUE: o_start_mul = 1'b1;
            RESP: begin
                o_done_0 = ~owner;
                o_done_1 = owner;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_0  <= 1'b0;
            pend_1  <= 1'b0;
            x_buf_0 <= '0;
            y_buf_0 <= '0;
            x_buf_1 <= '0;
            y_buf_1 <= '0;
        end else begin
            if (take_0) begin
                pend_0  <= 1'b1;
                x_buf_0 <= i_x_0;
                y_buf_0 <= i_y_0;
            end else if (state == ISSUE && !owner) begin
                pend_0 <= 1'b0;
            end
            if (take_1) begin
                pend_1  <= 1'b1;
                x_buf_1 <= i_x_1;
                y_buf_1 <= i_y_1;
            end else if (state == ISSUE && owner) begin
                pend_1 <= 1'b0;
            end
        end
    end

    // Grant is decided in IDLE so the operands are already on the multiplier bus during ISSUE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr      <= 1'b0;
            owner   <= 1'b0;
            o_x_mul <= '0;
            o_y_mul <= '0;
        end else if (issue_sel) begin
            rr      <= ~grant;
            owner   <= grant;
            o_x_mul <= grant ? x_buf_1 : x_buf_0;
            o_y_mul <= grant ? y_buf_1 : y_buf_0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (state == ISSUE) begin
            count <= '0;
        end else if (state == WAIT && !timed_out) begin
            count <= count + 1'b1;
        end
    end

    // A stalled multiplier still produces a (zero) response so the owner never deadlocks.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_res_0       <= '0;
            o_res_1       <= '0;
            o_err_timeout <= 1'b0;
        end else if (state == WAIT) begin
            if (i_done_mul) begin
                if (owner) o_res_1 <= i_o_mul;
                else       o_res_0 <= i_o_mul;
            end else if (timed_out) begin
                o_err_timeout <= 1'b1;
                if (owner) o_res_1 <= '0;
                else       o_res_0 <= '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err_proto <= 1'b0;
        end else if ((i_start_0 && busy_0) || (i_start_1 && busy_1)) begin
            o_err_proto <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gf32_mul_arbiter.sv
// Self-checking bench: XOR stub multiplier with 3-cycle latency, a transaction-level model
// checked every cycle, and directed scenarios with hand-computed results.
module tb_gf32_mul_arbiter;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_0, start_1;
    logic [WIDTH-1:0] x_0, y_0, x_1, y_1;
    logic [WIDTH-1:0] res_0, res_1;
    logic             done_0, done_1;
    logic             start_mul;
    logic [WIDTH-1:0] x_mul, y_mul, o_mul;
    logic             done_mul;
    logic             busy, err_proto, err_timeout;
    logic             stub_on;
    logic [2:0]       pipe;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    gf32_mul_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_start_0(start_0), .i_x_0(x_0), .i_y_0(y_0), .o_res_0(res_0), .o_done_0(done_0),
        .i_start_1(start_1), .i_x_1(x_1), .i_y_1(y_1), .o_res_1(res_1), .o_done_1(done_1),
        .o_start_mul(start_mul), .o_x_mul(x_mul), .o_y_mul(y_mul),
        .i_o_mul(o_mul), .i_done_mul(done_mul),
        .o_busy(busy), .o_err_proto(err_proto), .o_err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Stub multiplier: done three cycles after start, result x ^ y; junk on the bus otherwise.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe <= 3'b000;
        else        pipe <= {pipe[1:0], start_mul};
    end
    assign done_mul = pipe[2] & stub_on;
    assign o_mul    = done_mul ? (x_mul ^ y_mul) : 32'hDEADBEEF;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Model: one waiting slot per port, at most one op in flight, round-robin between waiters.
    bit          wv[2];
    logic [31:0] wx[2], wy[2];
    int          wacc[2];
    bit          inflight, owner_m, rr_m, exp_proto, exp_to;
    int          issue_c, resp_due, last_resp;
    logic [31:0] pend_val, exp_val;
    logic [31:0] held[2];
    int          dcnt[2];
    int          dlog[64];
    int          dlog_n = 0;

    always @(negedge clk) begin : model
        bit e0, e1, ed0, ed1, exp_start, exp_busy, m0, m1, g;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                wv[k] = 0; held[k] = '0;
            end
            inflight = 0; owner_m = 0; rr_m = 0; exp_proto = 0; exp_to = 0;
            resp_due = -1; last_resp = cyc - 10;
            checkOutput("rst_ctrl", 32'({start_mul, done_0, done_1, busy, err_proto, err_timeout}), 32'h0);
            checkOutput("rst_res_0", res_0, 32'h0);
            checkOutput("rst_res_1", res_1, 32'h0);
            checkOutput("rst_x_mul", x_mul, 32'h0);
            checkOutput("rst_y_mul", y_mul, 32'h0);
        end else begin
            exp_busy = wv[0] | wv[1] | inflight;
            if (inflight && resp_due < 0 && cyc == issue_c + TIMEOUT + 1) begin
                resp_due = cyc; exp_val = '0; exp_to = 1;
            end
            ed0 = inflight && resp_due == cyc && !owner_m;
            ed1 = inflight && resp_due == cyc && owner_m;
            checkBit("done_0", done_0, ed0);
            checkBit("done_1", done_1, ed1);
            if (ed0 || ed1) begin
                held[owner_m] = exp_val;
                dcnt[owner_m]++;
                if (dlog_n < 64) dlog[dlog_n] = int'(owner_m);
                dlog_n++;
                inflight  = 0;
                last_resp = cyc;
            end
            checkOutput("res_0", res_0, held[0]);
            checkOutput("res_1", res_1, held[1]);
            e0 = wv[0] && wacc[0] <= cyc - 2;
            e1 = wv[1] && wacc[1] <= cyc - 2;
            exp_start = !inflight && (e0 || e1) && cyc >= last_resp + 2;
            checkBit("start_mul", start_mul, exp_start);
            if (exp_start) begin
                g = (e0 && e1) ? rr_m : e1;
                checkOutput("x_mul", x_mul, wx[g]);
                checkOutput("y_mul", y_mul, wy[g]);
                wv[g] = 0; rr_m = !g; inflight = 1; owner_m = g;
                issue_c = cyc; resp_due = -1; pend_val = wx[g] ^ wy[g];
            end
            checkBit("busy", busy, exp_busy);
            checkBit("err_proto", err_proto, exp_proto);
            checkBit("err_timeout", err_timeout, exp_to);
            if (inflight && resp_due < 0 && done_mul && cyc > issue_c && cyc <= issue_c + TIMEOUT) begin
                resp_due = cyc + 1; exp_val = pend_val;
            end
            m0 = wv[0] || (inflight && !owner_m);
            m1 = wv[1] || (inflight && owner_m);
            if (start_0) begin
                if (m0) exp_proto = 1;
                else begin wv[0] = 1; wx[0] = x_0; wy[0] = y_0; wacc[0] = cyc; end
            end
            if (start_1) begin
                if (m1) exp_proto = 1;
                else begin wv[1] = 1; wx[1] = x_1; wy[1] = y_1; wacc[1] = cyc; end
            end
        end
    end

    task automatic applyStimulus(input bit s0, input logic [31:0] xa, input logic [31:0] ya,
                                 input bit s1, input logic [31:0] xb, input logic [31:0] yb);
        @(posedge clk); #1;
        start_0 = s0; x_0 = xa; y_0 = ya;
        start_1 = s1; x_1 = xb; y_1 = yb;
        @(posedge clk); #1;
        start_0 = 1'b0; start_1 = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (busy && n < budget);
        checkBit({name, "_idle"}, busy, 1'b0);
    endtask

    task automatic doReset();
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int base0, base1, ln, n0, n1, alt_bad, n;
        rst_n = 1'b0; stub_on = 1'b1;
        start_0 = 0; start_1 = 0; x_0 = 0; y_0 = 0; x_1 = 0; y_1 = 0;
        dcnt[0] = 0; dcnt[1] = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] single request");
        base0 = dcnt[0]; base1 = dcnt[1];
        applyStimulus(1, 32'h00000003, 32'h00000005, 0, 32'h0, 32'h0);
        waitIdle("single", 40);
        checkOutput("single_res_0", res_0, 32'h00000006);
        checkOutput("single_done0_cnt", 32'(dcnt[0] - base0), 32'd1);
        checkOutput("single_done1_cnt", 32'(dcnt[1] - base1), 32'd0);

        $display("[TB] simultaneous starts after reset");
        doReset();
        ln = dlog_n;
        applyStimulus(1, 32'h11111111, 32'h01010101, 1, 32'h22222222, 32'h02020202);
        waitIdle("simul", 60);
        checkOutput("simul_res_0", res_0, 32'h10101010);
        checkOutput("simul_res_1", res_1, 32'h20202020);
        checkOutput("simul_done_cnt", 32'(dlog_n - ln), 32'd2);
        checkOutput("simul_first_owner", 32'(dlog[ln]), 32'd0);
        checkOutput("simul_second_owner", 32'(dlog[ln + 1]), 32'd1);

        $display("[TB] fairness, 8 ops per port");
        ln = dlog_n; n0 = 1; n1 = 1;
        applyStimulus(1, 32'h00000100, 32'h00000001, 1, 32'h00010000, 32'h00000002);
        for (int c = 0; c < 600 && !(n0 == 8 && n1 == 8 && !busy); c++) begin
            @(posedge clk); #1;
            start_0 = done_0 && n0 < 8;
            start_1 = done_1 && n1 < 8;
            if (start_0) begin x_0 = 32'h00000100 + 32'(n0); y_0 = 32'(n0 * 3); n0++; end
            if (start_1) begin x_1 = 32'h00010000 + 32'(n1); y_1 = 32'(n1 * 5); n1++; end
        end
        start_0 = 1'b0; start_1 = 1'b0;
        checkOutput("fair_done_cnt", 32'(dlog_n - ln), 32'd16);
        checkOutput("fair_first_owner", 32'(dlog[ln]), 32'd0);
        alt_bad = 0;
        for (int i = ln + 1; i < ln + 16 && i < 64; i++)
            if (dlog[i] == dlog[i - 1]) alt_bad++;
        checkOutput("fair_alternation_breaks", 32'(alt_bad), 32'd0);
        checkBit("fair_err_proto", err_proto, 1'b0);
        checkBit("fair_err_timeout", err_timeout, 1'b0);

        $display("[TB] protocol violation on port 1");
        base1 = dcnt[1];
        applyStimulus(0, 32'h0, 32'h0, 1, 32'h0000F00F, 32'h0F0F0000);
        @(posedge clk); #1;
        start_1 = 1'b1; x_1 = 32'hFFFF0000; y_1 = 32'h00000001;
        @(posedge clk); #1;
        start_1 = 1'b0;
        waitIdle("proto", 60);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("proto_done1_cnt", 32'(dcnt[1] - base1), 32'd1);
        checkOutput("proto_res_1", res_1, 32'h0F0FF00F);
        checkBit("proto_err_sticky", err_proto, 1'b1);

        $display("[TB] multiplier timeout");
        base0 = dcnt[0];
        stub_on = 1'b0;
        applyStimulus(1, 32'hAAAA0000, 32'h00005555, 0, 32'h0, 32'h0);
        waitIdle("timeout", 60);
        checkBit("timeout_err", err_timeout, 1'b1);
        checkOutput("timeout_res_0", res_0, 32'h0);
        checkOutput("timeout_done0_cnt", 32'(dcnt[0] - base0), 32'd1);
        stub_on = 1'b1;

        $display("[TB] asynchronous reset during WAIT");
        doReset();
        applyStimulus(0, 32'h0, 32'h0, 1, 32'h000000FF, 32'h00000F0F);
        n = 0;
        while (!start_mul && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkBit("arst_issue_seen", start_mul, 1'b1);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        checkOutput("arst_ctrl", 32'({start_mul, done_0, done_1, busy, err_proto, err_timeout}), 32'h0);
        checkOutput("arst_x_mul", x_mul, 32'h0);
        checkOutput("arst_y_mul", y_mul, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        base0 = dcnt[0]; base1 = dcnt[1];
        repeat (6) @(posedge clk);
        #1;
        checkOutput("arst_no_stale_done", 32'(dcnt[1] - base1), 32'd0);
        applyStimulus(1, 32'h12345678, 32'h0F0F0F0F, 0, 32'h0, 32'h0);
        waitIdle("arst_after", 40);
        checkOutput("arst_after_res_0", res_0, 32'h1D3B5977);
        checkOutput("arst_after_done0_cnt", 32'(dcnt[0] - base0), 32'd1);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
